ip_rx_ctrl: RTL and testbench

IP receive dispatcher between `ip_rx` and the layer-4 receivers (`udp_rx`, `icmp_rx`). It holds the packet, header fields and data from `ip_rx`, then checks the destination address and protocol. It forwards the payload byte stream to exactly one downstream receiver, or drops it, and returns the completion handshake to `ip_rx`. It keeps four saturating packet counters and a timeout guard so that a stalled receiver cannot hang the IP path.

---
 rtl/ip_rx_ctrl_if.sv | 66 ++++++
 rtl/ip_rx_ctrl.sv | 155 +++++++++++++++
 tb/tb_ip_rx_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_rx_ctrl_if.sv
// Bundle between ip_rx, the dispatcher and the layer-4 receivers.
// The slave view is the dispatcher; the master view drives it.
interface ip_rx_ctrl_if;
    logic        ip_fs;
    logic        ip_fd;
    logic [7:0]  ip_mode;
    logic [31:0] src_ip_addr;
    logic [31:0] det_ip_addr;
    logic [7:0]  mode_rxd;

    logic        fs_udp;
    logic        fd_udp;
    logic [7:0]  rxd_udp;
    logic        fs_icmp;
    logic        fd_icmp;
    logic [7:0]  rxd_icmp;

    logic [31:0] src_ip;
    logic        clr_stat;
    logic [15:0] cnt_udp;
    logic [15:0] cnt_icmp;
    logic [15:0] cnt_drop;
    logic [15:0] cnt_tout;

    modport slave (
        input  ip_fs,
        input  ip_mode,
        input  src_ip_addr,
        input  det_ip_addr,
        input  mode_rxd,
        input  fd_udp,
        input  fd_icmp,
        input  clr_stat,
        output ip_fd,
        output fs_udp,
        output rxd_udp,
        output fs_icmp,
        output rxd_icmp,
        output src_ip,
        output cnt_udp,
        output cnt_icmp,
        output cnt_drop,
        output cnt_tout
    );

    modport master (
        output ip_fs,
        output ip_mode,
        output src_ip_addr,
        output det_ip_addr,
        output mode_rxd,
        output fd_udp,
        output fd_icmp,
        output clr_stat,
        input  ip_fd,
        input  fs_udp,
        input  rxd_udp,
        input  fs_icmp,
        input  rxd_icmp,
        input  src_ip,
        input  cnt_udp,
        input  cnt_icmp,
        input  cnt_drop,
        input  cnt_tout
    );
endinterface

// File: rtl/ip_rx_ctrl.sv
// IP receive dispatcher: routes ip_rx payload to UDP, ICMP or drop,
// with saturating statistics and a stall timeout on the downstream side.
module ip_rx_ctrl #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0002,
    parameter logic [15:0] TIMEOUT  = 16'd4000
) (
    input  logic        clk,
    input  logic        rst,
    ip_rx_ctrl_if.slave bus
);

    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_WAIT = 8'h01,
        S_UDP  = 8'h02,
        S_ICMP = 8'h03,
        S_DROP = 8'h04,
        S_DONE = 8'h05
    } state_e;

    localparam logic [7:0]  PROTO_UDP  = 8'h11;
    localparam logic [7:0]  PROTO_ICMP = 8'h01;
    localparam logic [31:0] BCAST_IP   = 32'hFFFF_FFFF;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;
    localparam logic [15:0] TOUT_LAST  = TIMEOUT - 16'd1;

    state_e      state_q;
    state_e      state_d;
    logic        ip_fs_d_q;
    logic        fs_udp_q;
    logic        fs_icmp_q;
    logic        ip_fd_q;
    logic [31:0] src_ip_q;
    logic [15:0] tout_q;
    logic [15:0] cnt_udp_q;
    logic [15:0] cnt_icmp_q;
    logic [15:0] cnt_drop_q;
    logic [15:0] cnt_tout_q;

    logic fs_rise;
    logic addr_ok;
    logic fd_sel;
    logic in_fwd;
    logic load_src;
    logic abort;
    logic timed_out;
    logic inc_udp;
    logic inc_icmp;
    logic inc_drop;

    function automatic logic [15:0] sat_inc(
        input logic [15:0] v,
        input logic        en
    );
        return (en && (v != CNT_MAX)) ? v + 16'd1 : v;
    endfunction

    assign fs_rise = bus.ip_fs & ~ip_fs_d_q;
    assign addr_ok = (bus.det_ip_addr == LOCAL_IP) ||
                     (bus.det_ip_addr == BCAST_IP);
    assign in_fwd  = (state_q == S_UDP) || (state_q == S_ICMP);
    assign fd_sel  = (state_q == S_UDP) ? bus.fd_udp : bus.fd_icmp;

    always_comb begin
        state_d   = state_q;
        load_src  = 1'b0;
        abort     = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (fs_rise) begin
                    load_src = 1'b1;
                    unique case (1'b1)
                        (addr_ok && (bus.ip_mode == PROTO_UDP)):
                            state_d = S_UDP;
                        (addr_ok && (bus.ip_mode == PROTO_ICMP)):
                            state_d = S_ICMP;
                        default:
                            state_d = S_DROP;
                    endcase
                end
            end
            S_UDP, S_ICMP: begin
                // done beats both abort and timeout
                if (fd_sel) begin
                    state_d = S_DONE;
                end else if (!bus.ip_fs) begin
                    state_d = S_WAIT;
                    abort   = 1'b1;
                end else if (tout_q == TOUT_LAST) begin
                    state_d   = S_DONE;
                    timed_out = 1'b1;
                end
            end
            S_DROP: state_d = S_DONE;
            S_DONE: begin
                if (!bus.ip_fs) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inc_udp  = (state_q == S_WAIT) && (state_d == S_UDP);
    assign inc_icmp = (state_q == S_WAIT) && (state_d == S_ICMP);
    assign inc_drop = ((state_q == S_WAIT) && (state_d == S_DROP)) ||
                      abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ip_fs_d_q  <= 1'b0;
            fs_udp_q   <= 1'b0;
            fs_icmp_q  <= 1'b0;
            ip_fd_q    <= 1'b0;
            src_ip_q   <= 32'h0;
            tout_q     <= 16'h0;
            cnt_udp_q  <= 16'h0;
            cnt_icmp_q <= 16'h0;
            cnt_drop_q <= 16'h0;
            cnt_tout_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            ip_fs_d_q <= bus.ip_fs;
            fs_udp_q  <= (state_d == S_UDP);
            fs_icmp_q <= (state_d == S_ICMP);
            ip_fd_q   <= (state_d == S_DONE);
            if (load_src) src_ip_q <= bus.src_ip_addr;
            tout_q <= in_fwd ? tout_q + 16'd1 : 16'h0;
            if (bus.clr_stat) begin
                cnt_udp_q  <= 16'h0;
                cnt_icmp_q <= 16'h0;
                cnt_drop_q <= 16'h0;
                cnt_tout_q <= 16'h0;
            end else begin
                cnt_udp_q  <= sat_inc(cnt_udp_q, inc_udp);
                cnt_icmp_q <= sat_inc(cnt_icmp_q, inc_icmp);
                cnt_drop_q <= sat_inc(cnt_drop_q, inc_drop);
                cnt_tout_q <= sat_inc(cnt_tout_q, timed_out);
            end
        end
    end

    assign bus.fs_udp   = fs_udp_q;
    assign bus.fs_icmp  = fs_icmp_q;
    assign bus.ip_fd    = ip_fd_q;
    assign bus.rxd_udp  = fs_udp_q ? bus.mode_rxd : 8'h00;
    assign bus.rxd_icmp = fs_icmp_q ? bus.mode_rxd : 8'h00;
    assign bus.src_ip   = src_ip_q;
    assign bus.cnt_udp  = cnt_udp_q;
    assign bus.cnt_icmp = cnt_icmp_q;
    assign bus.cnt_drop = cnt_drop_q;
    assign bus.cnt_tout = cnt_tout_q;

endmodule

// File: tb/tb_ip_rx_ctrl.sv
// Directed bench for ip_rx_ctrl: per-packet expectations from the routing
// rules, checked every cycle, plus literal spot checks.
module tb_ip_rx_ctrl;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0002;
    localparam logic [15:0] TOUT     = 16'd16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ip_rx_ctrl_if bus ();

    ip_rx_ctrl #(
        .LOCAL_IP(LOCAL_IP),
        .TIMEOUT (TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        e_fs_udp  = 1'b0;
    logic        e_fs_icmp = 1'b0;
    logic        e_ip_fd   = 1'b0;
    logic [31:0] e_src     = 32'h0;
    int          m_udp     = 0;
    int          m_icmp    = 0;
    int          m_drop    = 0;
    int          m_tout    = 0;
    bit          cmp_en    = 1'b0;
    int          fsu_cycles = 0;
    int          fsi_cycles = 0;
    logic [7:0]  cap[$];

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("fs_udp", {31'h0, bus.fs_udp}, {31'h0, e_fs_udp});
            chk("fs_icmp", {31'h0, bus.fs_icmp}, {31'h0, e_fs_icmp});
            chk("ip_fd", {31'h0, bus.ip_fd}, {31'h0, e_ip_fd});
            chk("rxd_udp", {24'h0, bus.rxd_udp},
                {24'h0, e_fs_udp ? bus.mode_rxd : 8'h00});
            chk("rxd_icmp", {24'h0, bus.rxd_icmp},
                {24'h0, e_fs_icmp ? bus.mode_rxd : 8'h00});
            chk("src_ip", bus.src_ip, e_src);
            chk("cnt_udp", {16'h0, bus.cnt_udp}, 32'(m_udp));
            chk("cnt_icmp", {16'h0, bus.cnt_icmp}, 32'(m_icmp));
            chk("cnt_drop", {16'h0, bus.cnt_drop}, 32'(m_drop));
            chk("cnt_tout", {16'h0, bus.cnt_tout}, 32'(m_tout));
        end
        if (bus.fs_udp === 1'b1) begin
            fsu_cycles++;
            cap.push_back(bus.rxd_udp);
        end
        if (bus.fs_icmp === 1'b1) fsi_cycles++;
    end

    // fd_at / abort_at: payload cycle index for fd or ip_fs drop, -1 = never
    task automatic send(input logic [31:0] dst, input logic [7:0] proto,
                        input logic [31:0] src, input int fd_at,
                        input int abort_at, input bit clr);
        int  route;
        bit  ok;
        bit  done;
        ok    = (dst == LOCAL_IP) || (dst == 32'hFFFF_FFFF);
        route = !ok ? 0 : (proto == 8'h11) ? 1 : (proto == 8'h01) ? 2 : 0;
        done  = 1'b0;
        bus.det_ip_addr = dst;
        bus.ip_mode     = proto;
        bus.src_ip_addr = src;
        bus.mode_rxd    = 8'hEE;
        bus.clr_stat    = clr;
        bus.ip_fs       = 1'b1;
        step();
        bus.clr_stat = 1'b0;
        e_src = src;
        if (clr) begin
            m_udp = 0; m_icmp = 0; m_drop = 0; m_tout = 0;
        end
        if (route == 0) begin
            if (!clr) m_drop = sat(m_drop);
            bus.mode_rxd = 8'h33;
            step();
            e_ip_fd = 1'b1;
            step();
            bus.ip_fs = 1'b0;
            step();
            e_ip_fd = 1'b0;
        end else begin
            if (route == 1) begin
                e_fs_udp = 1'b1;
                if (!clr) m_udp = sat(m_udp);
            end else begin
                e_fs_icmp = 1'b1;
                if (!clr) m_icmp = sat(m_icmp);
            end
            for (int j = 0; j < int'(TOUT); j++) begin
                bus.mode_rxd = 8'h10 + 8'(j);
                if (j == abort_at) bus.ip_fs = 1'b0;
                if (route == 1) bus.fd_udp = (j == fd_at);
                else bus.fd_icmp = (j == fd_at);
                step();
                bus.fd_udp  = 1'b0;
                bus.fd_icmp = 1'b0;
                if (j == fd_at) begin
                    e_fs_udp = 1'b0; e_fs_icmp = 1'b0; e_ip_fd = 1'b1;
                    done = 1'b1;
                    break;
                end else if (j == abort_at) begin
                    e_fs_udp = 1'b0; e_fs_icmp = 1'b0;
                    m_drop = sat(m_drop);
                    break;
                end else if (j == int'(TOUT) - 1) begin
                    e_fs_udp = 1'b0; e_fs_icmp = 1'b0; e_ip_fd = 1'b1;
                    m_tout = sat(m_tout);
                    done = 1'b1;
                end
            end
            bus.mode_rxd = 8'hA5;
            if (done) begin
                if (bus.ip_fs) begin
                    step();
                    bus.ip_fs = 1'b0;
                end
                step();
                e_ip_fd = 1'b0;
            end
        end
        bus.mode_rxd = 8'h5A;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ip_fs       = 1'b0;
        bus.ip_mode     = 8'h00;
        bus.src_ip_addr = 32'h0;
        bus.det_ip_addr = 32'h0;
        bus.mode_rxd    = 8'h5A;
        bus.fd_udp      = 1'b0;
        bus.fd_icmp     = 1'b0;
        bus.clr_stat    = 1'b0;
        rst = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_fs_udp", {31'h0, bus.fs_udp}, 32'h0);
        chk("rst_cnt_udp", {16'h0, bus.cnt_udp}, 32'h0);
        rst = 1'b0;
        step();
        step();
        step();

        // UDP to local, 8 bytes, fd on the last byte cycle
        cap.delete();
        fsu_cycles = 0;
        fsi_cycles = 0;
        send(LOCAL_IP, 8'h11, 32'h0A00_0001, 7, -1, 1'b0);
        chk("lit_udp_bytes", 32'(cap.size()), 32'd8);
        if (cap.size() == 8) begin
            chk("lit_byte0", {24'h0, cap[0]}, 32'h10);
            chk("lit_byte7", {24'h0, cap[7]}, 32'h17);
        end
        chk("lit_cnt_udp1", {16'h0, bus.cnt_udp}, 32'd1);
        chk("lit_no_icmp", 32'(fsi_cycles), 32'd0);
        chk("lit_src", bus.src_ip, 32'h0A00_0001);

        // ICMP broadcast, UDP to foreign host, TCP to local
        send(32'hFFFF_FFFF, 8'h01, 32'h0A00_0002, 3, -1, 1'b0);
        chk("lit_cnt_icmp1", {16'h0, bus.cnt_icmp}, 32'd1);
        fsu_cycles = 0;
        fsi_cycles = 0;
        send(32'h0A00_0009, 8'h11, 32'h0A00_0003, -1, -1, 1'b0);
        chk("lit_drop_fs", 32'(fsu_cycles), 32'd0);
        chk("lit_cnt_drop1", {16'h0, bus.cnt_drop}, 32'd1);
        send(LOCAL_IP, 8'h06, 32'h0A00_0004, -1, -1, 1'b0);
        chk("lit_tcp_fs", 32'(fsu_cycles + fsi_cycles), 32'd0);
        chk("lit_cnt_drop2", {16'h0, bus.cnt_drop}, 32'd2);

        // timeout, then fd coinciding with the timeout cycle
        fsu_cycles = 0;
        send(LOCAL_IP, 8'h11, 32'h0A00_0005, -1, -1, 1'b0);
        chk("lit_tout_cycles", 32'(fsu_cycles), 32'd16);
        chk("lit_cnt_tout1", {16'h0, bus.cnt_tout}, 32'd1);
        send(LOCAL_IP, 8'h11, 32'h0A00_0006, 15, -1, 1'b0);
        chk("lit_fd_wins", {16'h0, bus.cnt_tout}, 32'd1);

        // abort mid-UDP, and fd together with ip_fs falling
        send(LOCAL_IP, 8'h11, 32'h0A00_0007, -1, 3, 1'b0);
        chk("lit_cnt_drop3", {16'h0, bus.cnt_drop}, 32'd3);
        send(LOCAL_IP, 8'h01, 32'h0A00_0008, 2, 2, 1'b0);

        // clear coinciding with entry to UDP
        send(LOCAL_IP, 8'h11, 32'h0A00_000A, 1, -1, 1'b1);
        chk("lit_clr_udp", {16'h0, bus.cnt_udp}, 32'd0);
        chk("lit_clr_drop", {16'h0, bus.cnt_drop}, 32'd0);

        // saturation
        force dut.cnt_udp_q = 16'hFFFE;
        #1;
        release dut.cnt_udp_q;
        m_udp = 65534;
        send(LOCAL_IP, 8'h11, 32'h0A00_000B, 0, -1, 1'b0);
        send(LOCAL_IP, 8'h11, 32'h0A00_000C, 0, -1, 1'b0);
        chk("lit_sat", {16'h0, bus.cnt_udp}, 32'h0000_FFFF);

        // reset mid-ICMP
        bus.det_ip_addr = LOCAL_IP;
        bus.ip_mode     = 8'h01;
        bus.src_ip_addr = 32'h0A00_000D;
        bus.ip_fs       = 1'b1;
        step();
        e_fs_icmp = 1'b1;
        e_src     = 32'h0A00_000D;
        m_icmp    = sat(m_icmp);
        step();
        rst = 1'b1;
        step();
        e_fs_icmp = 1'b0;
        e_src = 32'h0;
        m_udp = 0; m_icmp = 0; m_drop = 0; m_tout = 0;
        chk("lit_rst_fs_icmp", {31'h0, bus.fs_icmp}, 32'h0);
        chk("lit_rst_cnt_icmp", {16'h0, bus.cnt_icmp}, 32'h0);
        bus.ip_fs = 1'b0;
        rst = 1'b0;
        step();
        step();
        step();
        send(LOCAL_IP, 8'h11, 32'h0A00_000E, 4, -1, 1'b0);
        chk("lit_post_rst_udp", {16'h0, bus.cnt_udp}, 32'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
